unpadding: RTL and testbench

//  Inverse of the padding stage: receives padded IWIDTH-bit blocks and strips the 10* padding from the final block.

---
 rtl/unpadding_pkg.sv | 19 +
 rtl/unpadding_msb_locator.sv | 25 ++
 rtl/unpadding.sv | 115 +++++++++++
 tb/tb_unpadding.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/unpadding_pkg.sv
// Shared types and default geometry for the unpadding block.
//   state_t     : IDLE (nothing held) / EMIT (block held, words going out)
//   DEF_IWIDTH  : default padded block width
//   DEF_BWIDTH  : default output word width
//   WORDS, IDXW, CNTW : words per block, marker index width and bit-count width at the defaults
package unpadding_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int DEF_IWIDTH = 64;
  localparam int DEF_BWIDTH = 32;
  localparam int WORDS      = DEF_IWIDTH / DEF_BWIDTH;
  localparam int IDXW       = $clog2(DEF_IWIDTH);
  localparam int CNTW       = $clog2(DEF_BWIDTH + 1);

endpackage

// File: rtl/unpadding_msb_locator.sv
// Combinational priority encoder: position of the highest set bit.
//   vec   : input vector
//   found : at least one bit of vec is set
//   idx   : index of the highest set bit (0 when nothing is set)
module msb_locator #(
  parameter int W = 64
) (
  input  logic [W-1:0]         vec,
  output logic                 found,
  output logic [$clog2(W)-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Ascending scan: the last hit wins, which is the highest set bit.
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = $clog2(W)'(i);
      end
    end
  end

endmodule

// File: rtl/unpadding.sv
// Strips 10* padding from the final block of a message and emits the payload
// as BWIDTH-bit words, low word first, each with a valid-bit count.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : padded block handshake (in_block, in_last)
//   out_valid/out_ready : payload word handshake (out_word, out_bits, out_last)
//   pad_error           : one-cycle pulse after accepting a final block with no marker
//
// state | meaning
// IDLE  | no block held, ready for input
// EMIT  | block held, presenting word idx
module unpadding
  import unpadding_pkg::*;
#(
  parameter int IWIDTH = DEF_IWIDTH,
  parameter int BWIDTH = DEF_BWIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IWIDTH-1:0]            in_block,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BWIDTH-1:0]            out_word,
  output logic [$clog2(BWIDTH+1)-1:0]  out_bits,
  output logic                         out_last,
  output logic                         pad_error
);

  localparam int NW = IWIDTH / BWIDTH;
  localparam int XW = (NW > 1) ? $clog2(NW) : 1;
  localparam int LW = $clog2(IWIDTH);
  localparam int CW = $clog2(BWIDTH + 1);

  state_t                   state_q, state_d;
  logic [NW-1:0][BWIDTH-1:0] held_q;
  logic                     last_q;
  logic [XW-1:0]            idx_q, lastidx_q;
  logic [CW-1:0]            fbits_q;

  logic                     found;
  logic [LW-1:0]            mpos;
  logic                     final_word, accept, advance;
  logic [IWIDTH-1:0]        payload;
  logic [XW-1:0]            cap_lastidx;
  logic [CW-1:0]            cap_fbits;
  int                       cap_li;

  msb_locator #(.W(IWIDTH)) u_loc (
    .vec   (in_block),
    .found (found),
    .idx   (mpos)
  );

  // The held block is stored already masked, so word selection needs no
  // per-word masking later; only the bit count of the final word differs.
  always_comb begin
    cap_li      = 0;
    payload     = in_block;
    cap_lastidx = XW'(NW - 1);
    cap_fbits   = CW'(BWIDTH);
    if (in_last) begin
      payload     = in_block & ~({IWIDTH{1'b1}} << mpos);
      cap_li      = (mpos == '0) ? 0 : (int'(mpos) - 1) / BWIDTH;
      cap_lastidx = XW'(cap_li);
      cap_fbits   = CW'(int'(mpos) - cap_li * BWIDTH);
    end
  end

  always_comb begin
    final_word = (idx_q == lastidx_q);
    in_ready   = !rst && ((state_q == IDLE) ||
                          ((state_q == EMIT) && final_word && out_ready));
    accept     = in_valid && in_ready;
    advance    = (state_q == EMIT) && out_ready;

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EMIT;
      EMIT:    if (advance && final_word && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_valid = (state_q == EMIT);
    out_word  = out_valid ? held_q[idx_q] : '0;
    out_bits  = out_valid ? (final_word ? fbits_q : CW'(BWIDTH)) : '0;
    out_last  = out_valid && last_q && final_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      held_q    <= '0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      lastidx_q <= '0;
      fbits_q   <= '0;
      pad_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      pad_error <= accept && in_last && !found;
      if (accept) begin
        held_q    <= payload;
        last_q    <= in_last;
        idx_q     <= '0;
        lastidx_q <= cap_lastidx;
        fbits_q   <= cap_fbits;
      end else if (advance && !final_word) begin
        idx_q <= idx_q + XW'(1);
      end
    end
  end

endmodule

// File: tb/tb_unpadding.sv
module tb_unpadding;

  localparam int IWIDTH = 64;
  localparam int BWIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IWIDTH-1:0] in_block;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [BWIDTH-1:0] out_word;
  logic [5:0]        out_bits;
  logic              out_last;
  logic              pad_error;

  int total = 0;
  int bad   = 0;

  unpadding #(.IWIDTH(IWIDTH), .BWIDTH(BWIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .pad_error (pad_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the block was accepted.
  task automatic push(input logic [63:0] blk, input logic lst);
    int n;
    n = 0;
    in_block = blk;
    in_last  = lst;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("push_in_ready_timeout", 64'(n < 20), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Checks the presented word at a negedge, lets it go, returns at next negedge.
  task automatic expect_word(input string tag, input logic [31:0] w,
                             input logic [5:0] bits, input logic lst);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_word"},  64'(out_word),  64'(w));
    chk({tag, "_bits"},  64'(out_bits),  64'(bits));
    chk({tag, "_last"},  64'(out_last),  64'(lst));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word",  64'(out_word),  64'd0);
    chk("rst_out_bits",  64'(out_bits),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_pad_error", 64'(pad_error), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    #1 chk("idle_in_ready", 64'(in_ready), 64'd1);

    // non-last block: two full words
    push(64'h0123_4567_89AB_CDEF, 1'b0);
    expect_word("nl_w0", 32'h89AB_CDEF, 6'd32, 1'b0);
    expect_word("nl_w1", 32'h0123_4567, 6'd32, 1'b0);
    chk("nl_idle", 64'(out_valid), 64'd0);

    // marker at bit 32
    push(64'h0000_0001_DEAD_BEEF, 1'b1);
    chk("l32_pad_error", 64'(pad_error), 64'd0);
    expect_word("l32", 32'hDEAD_BEEF, 6'd32, 1'b1);
    chk("l32_idle", 64'(out_valid), 64'd0);

    // marker at bit 8
    push(64'h0000_0000_0000_01A5, 1'b1);
    expect_word("l8", 32'h0000_00A5, 6'd8, 1'b1);

    // marker at bit 63
    push(64'h8000_0000_0000_0001, 1'b1);
    expect_word("l63_w0", 32'h0000_0001, 6'd32, 1'b0);
    expect_word("l63_w1", 32'h0000_0000, 6'd31, 1'b1);

    // marker at bit 0: empty payload, not an error
    push(64'h1, 1'b1);
    chk("l0_pad_error", 64'(pad_error), 64'd0);
    expect_word("l0", 32'h0, 6'd0, 1'b1);

    // all-zero final block
    push(64'h0, 1'b1);
    chk("zero_pad_error_hi", 64'(pad_error), 64'd1);
    expect_word("zero", 32'h0, 6'd0, 1'b1);
    chk("zero_pad_error_lo", 64'(pad_error), 64'd0);

    // backpressure on the final word with a block waiting
    push(64'h0123_4567_89AB_CDEF, 1'b0);
    expect_word("bp_w0", 32'h89AB_CDEF, 6'd32, 1'b0);
    out_ready = 1'b0;
    in_block  = 64'h0000_0001_DEAD_BEEF;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_word",     64'(out_word),  64'h0123_4567);
      chk("bp_bits",     64'(out_bits),  64'd32);
      chk("bp_last",     64'(out_last),  64'd0);
      chk("bp_valid",    64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_word("bp_w1", 32'h0123_4567, 6'd32, 1'b0);
    chk("bp_idle", 64'(out_valid), 64'd0);

    // continuous streaming: A (non-last), B (L=63), C (L=8)
    in_block = 64'hAAAA_0001_BBBB_0002;
    in_last  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("st_a0_in_ready", 64'(in_ready), 64'd0);
    chk("st_a0_word",     64'(out_word), 64'hBBBB_0002);
    @(posedge clk);
    @(negedge clk);
    chk("st_a1_word",     64'(out_word), 64'hAAAA_0001);
    chk("st_a1_in_ready", 64'(in_ready), 64'd1);
    in_block = 64'h8000_0000_0000_0001;
    in_last  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("st_b0_valid", 64'(out_valid), 64'd1);
    chk("st_b0_word",  64'(out_word),  64'h0000_0001);
    chk("st_b0_bits",  64'(out_bits),  64'd32);
    @(posedge clk);
    @(negedge clk);
    chk("st_b1_bits",     64'(out_bits), 64'd31);
    chk("st_b1_last",     64'(out_last), 64'd1);
    chk("st_b1_in_ready", 64'(in_ready), 64'd1);
    in_block = 64'h0000_0000_0000_01A5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("st_c_valid", 64'(out_valid), 64'd1);
    chk("st_c_word",  64'(out_word),  64'h0000_00A5);
    chk("st_c_bits",  64'(out_bits),  64'd8);
    chk("st_c_last",  64'(out_last),  64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("st_idle", 64'(out_valid), 64'd0);

    // reset while word 0 of a two-word block is presented
    push(64'hCAFE_BABE_1234_5678, 1'b0);
    chk("rm_w0_word", 64'(out_word), 64'h1234_5678);
    rst = 1'b1;
    #1;
    chk("rm_out_valid", 64'(out_valid), 64'd0);
    chk("rm_in_ready",  64'(in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rm_after_valid", 64'(out_valid), 64'd0);
    push(64'h0000_0000_0001_5555, 1'b1);
    expect_word("rm_new", 32'h0000_5555, 6'd16, 1'b1);
    chk("rm_no_old_word", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
